// File: rtl/upd_board_io.sv
// Board-level I/O for the UPduino Xosera top: PLL-lock model with core reset
// sequencing, registered video/bus pins, DDR pixel-clock output and warm-boot latch.
module upd_board_io #(
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned VIDEO_W     = 15
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               pll_resetb_i,
  output logic               pll_lock_o,
  output logic               core_reset_o,
  input  logic [VIDEO_W-1:0] video_i,
  output logic [VIDEO_W-1:0] video_o,
  output logic               dv_clk_o,
  input  logic               bus_cs_n_i,
  input  logic               bus_rd_nwr_i,
  input  logic [7:0]         bus_data_core_i,
  output logic [7:0]         bus_data_o,
  output logic               bus_data_oe_o,
  input  logic               reconfig_i,
  input  logic [1:0]         boot_select_i,
  output logic               boot_o,
  output logic [1:0]         boot_sel_o
);

  localparam logic [7:0] LOCK_VAL = 8'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  lock_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fall_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_RESET;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // PLL reset wins over everything, including the edge that would have locked.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!pll_resetb_i) begin
      state_d = ST_COUNT;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_COUNT;
          cnt_d   = 8'd0;
        end
        ST_COUNT: begin
          if (cnt_q != LOCK_VAL) cnt_d = cnt_q + 8'd1;
          if (cnt_d == LOCK_VAL) state_d = ST_LOCKED;
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default: begin
          state_d = ST_RESET;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  assign pll_lock_o = (state_q == ST_LOCKED);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      core_reset_o <= 1'b1;
      video_o      <= '0;
      bus_data_o   <= 8'd0;
      boot_o       <= 1'b0;
      boot_sel_o   <= 2'd0;
    end else begin
      core_reset_o <= !pll_lock_o;
      video_o      <= video_i;
      bus_data_o   <= bus_data_core_i;
      if (reconfig_i && !core_reset_o && !boot_o) begin
        boot_o     <= 1'b1;
        boot_sel_o <= boot_select_i;
      end
    end
  end

  // DDR output: rising-edge data is constant 0, falling-edge data is 1 once out of reset.
  always_ff @(negedge clk or negedge reset_n_i) begin
    if (!reset_n_i) fall_q <= 1'b0;
    else            fall_q <= 1'b1;
  end

  assign dv_clk_o = clk ? 1'b0 : fall_q;

  assign bus_data_oe_o = !bus_cs_n_i && bus_rd_nwr_i;

endmodule

// File: tb/tb_upd_board_io.sv
// Randomized and directed bench for upd_board_io against an edge-counting
// reference model of lock timing, core reset, bus/video registers and warm boot.
module tb_upd_board_io;
  localparam int LOCK = 16;
  localparam int VW   = 15;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n_i = 1'b0;
  logic          pll_resetb_i = 1'b1;
  logic          pll_lock_o, core_reset_o;
  logic [VW-1:0] video_i = '0;
  logic [VW-1:0] video_o;
  logic          dv_clk_o;
  logic          bus_cs_n_i = 1'b1;
  logic          bus_rd_nwr_i = 1'b0;
  logic [7:0]    bus_data_core_i = 8'd0;
  logic [7:0]    bus_data_o;
  logic          bus_data_oe_o;
  logic          reconfig_i = 1'b0;
  logic [1:0]    boot_select_i = 2'd0;
  logic          boot_o;
  logic [1:0]    boot_sel_o;

  upd_board_io #(.LOCK_CYCLES(LOCK), .VIDEO_W(VW)) dut (
    .clk(clk), .reset_n_i(reset_n_i), .pll_resetb_i(pll_resetb_i),
    .pll_lock_o(pll_lock_o), .core_reset_o(core_reset_o),
    .video_i(video_i), .video_o(video_o), .dv_clk_o(dv_clk_o),
    .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i),
    .bus_data_core_i(bus_data_core_i), .bus_data_o(bus_data_o),
    .bus_data_oe_o(bus_data_oe_o), .reconfig_i(reconfig_i),
    .boot_select_i(boot_select_i), .boot_o(boot_o), .boot_sel_o(boot_sel_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] exp_q[$];

  // Reference model: lock once enough edges have been seen since the last
  // restart (reset release needs LOCK+1, a PLL-reset restart needs LOCK).
  int            m_seen, m_need;
  logic          m_lock, m_core, m_boot, m_fall;
  logic [1:0]    m_sel;
  logic [VW-1:0] m_video;
  logic [7:0]    m_bus;

  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_seen = 0; m_need = LOCK + 1; m_lock = 0; m_core = 1;
      m_boot = 0; m_sel = 2'd0; m_video = '0; m_bus = 8'd0;
    end else begin
      if (reconfig_i && !m_core && !m_boot) begin
        m_boot = 1; m_sel = boot_select_i;
      end
      m_core = !m_lock;
      if (!pll_resetb_i) begin
        m_seen = 0; m_need = LOCK; m_lock = 0;
      end else begin
        if (m_seen < 1000) m_seen++;
        m_lock = (m_seen >= m_need);
      end
      m_video = video_i;
      m_bus   = bus_data_core_i;
    end
  end

  always @(negedge clk or negedge reset_n_i) begin
    if (!reset_n_i) m_fall = 0;
    else            m_fall = 1;
  end

  // driver tasks
  task automatic release_reset();
    @(negedge clk); #1;
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    video_i = 15'h1234; bus_data_core_i = 8'h77;
    repeat (3) @(negedge clk);
    #1;
    n_cmp += 7;
    if (pll_lock_o !== 1'b0) begin n_err++; $display("FAIL reset_lock got=%b exp=0", pll_lock_o); end
    if (core_reset_o !== 1'b1) begin n_err++; $display("FAIL reset_core got=%b exp=1", core_reset_o); end
    if (video_o !== '0) begin n_err++; $display("FAIL reset_video got=%h exp=0", video_o); end
    if (bus_data_o !== 8'd0) begin n_err++; $display("FAIL reset_bus got=%h exp=0", bus_data_o); end
    if (boot_o !== 1'b0) begin n_err++; $display("FAIL reset_boot got=%b exp=0", boot_o); end
    if (boot_sel_o !== 2'd0) begin n_err++; $display("FAIL reset_sel got=%b exp=0", boot_sel_o); end
    if (dv_clk_o !== 1'b0) begin n_err++; $display("FAIL reset_dv_low got=%b exp=0", dv_clk_o); end
    @(posedge clk); #1;
    n_cmp++;
    if (dv_clk_o !== 1'b0) begin n_err++; $display("FAIL reset_dv_high got=%b exp=0", dv_clk_o); end
  endtask

  task automatic test_lock();
    release_reset();
    for (int e = 1; e <= LOCK + 3; e++) begin
      @(posedge clk); #1;
      n_cmp += 3;
      if (pll_lock_o !== m_lock) begin n_err++; $display("FAIL lock_edge%0d got=%b exp=%b", e, pll_lock_o, m_lock); end
      if (core_reset_o !== m_core) begin n_err++; $display("FAIL core_edge%0d got=%b exp=%b", e, core_reset_o, m_core); end
      if (pll_lock_o !== (e >= LOCK + 1)) begin n_err++; $display("FAIL lock_latency edge%0d got=%b", e, pll_lock_o); end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      n_cmp += 3;
      if (pll_lock_o !== 1'b1) begin n_err++; $display("FAIL lock_stable got=%b exp=1", pll_lock_o); end
      if (core_reset_o !== 1'b0) begin n_err++; $display("FAIL core_stable got=%b exp=0", core_reset_o); end
      if (dv_clk_o !== 1'b1) begin n_err++; $display("FAIL dv_low_phase got=%b exp=1", dv_clk_o); end
      video_i = VW'($urandom);
      bus_data_core_i = 8'($urandom);
    end
  endtask

  task automatic test_pll_reset();
    @(negedge clk); #1;
    pll_resetb_i = 1'b0;
    for (int e = 1; e <= LOCK + 6; e++) begin
      @(negedge clk); #1;
      n_cmp += 2;
      if (pll_lock_o !== m_lock) begin n_err++; $display("FAIL pllrst_lock step%0d got=%b exp=%b", e, pll_lock_o, m_lock); end
      if (core_reset_o !== m_core) begin n_err++; $display("FAIL pllrst_core step%0d got=%b exp=%b", e, core_reset_o, m_core); end
      if (e == 3) pll_resetb_i = 1'b1;
    end
    n_cmp++;
    if (pll_lock_o !== 1'b1) begin n_err++; $display("FAIL pllrst_relock got=%b exp=1", pll_lock_o); end
  endtask

  task automatic test_lock_boundary();
    pll_resetb_i = 1'b0;
    @(negedge clk); #1;
    pll_resetb_i = 1'b1;
    repeat (LOCK - 1) @(negedge clk);
    #1;
    pll_resetb_i = 1'b0;
    @(negedge clk); #1;
    n_cmp += 2;
    if (pll_lock_o !== 1'b0) begin n_err++; $display("FAIL boundary_nolock got=%b exp=0", pll_lock_o); end
    if (pll_lock_o !== m_lock) begin n_err++; $display("FAIL boundary_model got=%b exp=%b", pll_lock_o, m_lock); end
    pll_resetb_i = 1'b1;
    repeat (LOCK + 1) @(negedge clk);
    #1;
    n_cmp++;
    if (pll_lock_o !== 1'b1) begin n_err++; $display("FAIL boundary_relock got=%b exp=1", pll_lock_o); end
  endtask

  task automatic test_video();
    logic [VW-1:0] vals[4];
    logic [VW-1:0] exp_v;
    vals[0] = VW'(16'h5A3C); vals[1] = VW'(16'h7FFF);
    vals[2] = VW'($urandom); vals[3] = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      video_i = vals[i];
      exp_q.push_back(vals[i]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_cmp += 2;
      if (video_o !== exp_v) begin n_err++; $display("FAIL video%0d got=%h exp=%h", i, video_o, exp_v); end
      if (dv_clk_o !== 1'b0) begin n_err++; $display("FAIL dv_high_phase got=%b exp=0", dv_clk_o); end
    end
  endtask

  task automatic test_bus();
    logic exp_oe;
    @(negedge clk); #1;
    bus_cs_n_i = 1'b0; bus_rd_nwr_i = 1'b1; bus_data_core_i = 8'hA5;
    #1;
    n_cmp++;
    if (bus_data_oe_o !== 1'b1) begin n_err++; $display("FAIL bus_oe_read got=%b exp=1", bus_data_oe_o); end
    @(negedge clk); #1;
    n_cmp++;
    if (bus_data_o !== 8'hA5) begin n_err++; $display("FAIL bus_data got=%h exp=a5", bus_data_o); end
    bus_rd_nwr_i = 1'b0; #1;
    n_cmp++;
    if (bus_data_oe_o !== 1'b0) begin n_err++; $display("FAIL bus_oe_write got=%b exp=0", bus_data_oe_o); end
    bus_rd_nwr_i = 1'b1; bus_cs_n_i = 1'b1; #1;
    n_cmp++;
    if (bus_data_oe_o !== 1'b0) begin n_err++; $display("FAIL bus_oe_nocs got=%b exp=0", bus_data_oe_o); end
    for (int i = 0; i < 8; i++) begin
      bus_cs_n_i = 1'($urandom); bus_rd_nwr_i = 1'($urandom); #1;
      exp_oe = (bus_cs_n_i == 1'b0) && (bus_rd_nwr_i == 1'b1);
      n_cmp++;
      if (bus_data_oe_o !== exp_oe) begin n_err++; $display("FAIL bus_oe_rand got=%b exp=%b", bus_data_oe_o, exp_oe); end
    end
  endtask

  task automatic test_boot_before_lock();
    reset_n_i = 1'b0;
    #2;
    release_reset();
    reconfig_i = 1'b1; boot_select_i = 2'b11;
    // held through the edge on which core_reset_o falls
    for (int e = 1; e <= LOCK + 2; e++) begin
      @(negedge clk); #1;
      n_cmp += 2;
      if (boot_o !== 1'b0) begin n_err++; $display("FAIL boot_prelock edge%0d got=%b exp=0", e, boot_o); end
      if (core_reset_o !== m_core) begin n_err++; $display("FAIL boot_prelock_core edge%0d got=%b exp=%b", e, core_reset_o, m_core); end
    end
    reconfig_i = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (boot_o !== 1'b0) begin n_err++; $display("FAIL boot_prelock_after got=%b exp=0", boot_o); end
  endtask

  task automatic test_boot();
    reconfig_i = 1'b1; boot_select_i = 2'b10;
    @(negedge clk); #1;
    reconfig_i = 1'b0; boot_select_i = 2'b00;
    n_cmp += 2;
    if (boot_o !== 1'b1) begin n_err++; $display("FAIL boot_set got=%b exp=1", boot_o); end
    if (boot_sel_o !== 2'b10) begin n_err++; $display("FAIL boot_sel got=%b exp=10", boot_sel_o); end
    reconfig_i = 1'b1; boot_select_i = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    reconfig_i = 1'b0;
    n_cmp += 2;
    if (boot_o !== 1'b1) begin n_err++; $display("FAIL boot_sticky got=%b exp=1", boot_o); end
    if (boot_sel_o !== 2'b10) begin n_err++; $display("FAIL boot_sel_held got=%b exp=10", boot_sel_o); end
  endtask

  task automatic test_async_reset();
    video_i = 15'h2AAA; bus_data_core_i = 8'h3C;
    @(posedge clk); #2;
    reset_n_i = 1'b0; #1;
    n_cmp += 6;
    if (boot_o !== 1'b0) begin n_err++; $display("FAIL async_boot got=%b exp=0", boot_o); end
    if (boot_sel_o !== 2'd0) begin n_err++; $display("FAIL async_sel got=%b exp=0", boot_sel_o); end
    if (pll_lock_o !== 1'b0) begin n_err++; $display("FAIL async_lock got=%b exp=0", pll_lock_o); end
    if (core_reset_o !== 1'b1) begin n_err++; $display("FAIL async_core got=%b exp=1", core_reset_o); end
    if (video_o !== '0) begin n_err++; $display("FAIL async_video got=%h exp=0", video_o); end
    if (bus_data_o !== 8'd0) begin n_err++; $display("FAIL async_bus got=%h exp=0", bus_data_o); end
    release_reset();
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    reset_n_i = 1'b0; #1;
    n_cmp += 4;
    if (dv_clk_o !== 1'b0) begin n_err++; $display("FAIL async_dv got=%b exp=0", dv_clk_o); end
    if (core_reset_o !== 1'b1) begin n_err++; $display("FAIL async_mid_core got=%b exp=1", core_reset_o); end
    if (video_o !== '0) begin n_err++; $display("FAIL async_mid_video got=%h exp=0", video_o); end
    if (bus_data_o !== 8'd0) begin n_err++; $display("FAIL async_mid_bus got=%h exp=0", bus_data_o); end
  endtask

  task automatic test_random();
    release_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      n_cmp += 8;
      if (pll_lock_o !== m_lock) begin n_err++; $display("FAIL rnd_lock cyc%0d got=%b exp=%b", i, pll_lock_o, m_lock); end
      if (core_reset_o !== m_core) begin n_err++; $display("FAIL rnd_core cyc%0d got=%b exp=%b", i, core_reset_o, m_core); end
      if (video_o !== m_video) begin n_err++; $display("FAIL rnd_video cyc%0d got=%h exp=%h", i, video_o, m_video); end
      if (bus_data_o !== m_bus) begin n_err++; $display("FAIL rnd_bus cyc%0d got=%h exp=%h", i, bus_data_o, m_bus); end
      if (boot_o !== m_boot) begin n_err++; $display("FAIL rnd_boot cyc%0d got=%b exp=%b", i, boot_o, m_boot); end
      if (boot_sel_o !== m_sel) begin n_err++; $display("FAIL rnd_sel cyc%0d got=%b exp=%b", i, boot_sel_o, m_sel); end
      if (dv_clk_o !== m_fall) begin n_err++; $display("FAIL rnd_dv cyc%0d got=%b exp=%b", i, dv_clk_o, m_fall); end
      if (bus_data_oe_o !== (!bus_cs_n_i && bus_rd_nwr_i)) begin n_err++; $display("FAIL rnd_oe cyc%0d got=%b", i, bus_data_oe_o); end
      video_i         = VW'($urandom);
      bus_data_core_i = 8'($urandom);
      bus_cs_n_i      = 1'($urandom);
      bus_rd_nwr_i    = 1'($urandom);
      pll_resetb_i    = ($urandom_range(0, 59) != 0);
      reconfig_i      = ($urandom_range(0, 29) == 0);
      boot_select_i   = 2'($urandom);
      if (i == 300) begin
        reset_n_i = 1'b0; #2;
        reset_n_i = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pll_reset();
    test_lock_boundary();
    test_video();
    test_bus();
    test_boot_before_lock();
    test_boot();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
